mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 17 +
 rtl/mux_rr_arbiter_if.sv | 32 +++
 rtl/mux_rr_arbiter_mux2.sv | 15 +
 rtl/mux_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
// Provides the owner-FSM state encoding and the owner identifiers
// stored in the "last owner" register and driven onto out_sel.
package mux_arb_pkg;

  // Owner FSM: nobody owns the output, A owns it, or B owns it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  // Owner identifiers; the value doubles as the out_sel encoding.
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bus bundle for mux_rr_arbiter.
// Carries both requester handshakes (valid/data in, ready out) and the
// registered output beat (valid/data/sel out, ready in).
//   master : environment side (drives requesters and out_ready)
//   slave  : arbiter side
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  import mux_arb_pkg::*;

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_rr_arbiter_mux2.sv
// Team 1-bit 2:1 mux cell.
//   a   : input selected when s = 0
//   b   : input selected when s = 1
//   s   : select
//   out : selected bit
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic out
);

  assign out = s ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output stage.
// A requester keeps ownership for up to MAX_BURST consecutive beats while
// the other one waits; with no contention the owner may continue forever.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester A/B handshakes and the registered output beat
// Readies are combinational; out_valid/out_data/out_sel are registered.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.slave   bus
);
  import mux_arb_pkg::*;

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_e           state_q,     state_d;
  logic             last_q,      last_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_sel_q,   out_sel_d;

  logic             load_s;
  logic             below_max_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic             keep_owner_s;
  logic [WIDTH-1:0] mux_out_s;

  // The output register can take a new beat when empty or being drained.
  assign load_s      = !out_valid_q || bus.out_ready;
  assign below_max_s = (cnt_q < MAX_CNT);

  // Grant decision; grants are already qualified by load so they double as readies.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (load_s) begin
      case (state_q)
        IDLE: begin
          if (bus.a_valid && bus.b_valid) begin
            // Contention from idle: the requester that did not own last wins.
            if (last_q == OWNER_A) begin
              grant_b_s = 1'b1;
            end else begin
              grant_a_s = 1'b1;
            end
          end else if (bus.a_valid) begin
            grant_a_s = 1'b1;
          end else if (bus.b_valid) begin
            grant_b_s = 1'b1;
          end else begin
            grant_a_s = 1'b0;
          end
        end
        OWN_A: begin
          if (bus.a_valid && (below_max_s || !bus.b_valid)) begin
            grant_a_s = 1'b1;
          end else if (bus.b_valid) begin
            grant_b_s = 1'b1;
          end else begin
            grant_a_s = 1'b0;
          end
        end
        OWN_B: begin
          if (bus.b_valid && (below_max_s || !bus.a_valid)) begin
            grant_b_s = 1'b1;
          end else if (bus.a_valid) begin
            grant_a_s = 1'b1;
          end else begin
            grant_b_s = 1'b0;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end else begin
      grant_a_s = 1'b0;
    end
  end

  assign bus.a_ready = grant_a_s;
  assign bus.b_ready = grant_b_s;

  // Data select: the mux select equals the out_sel value being loaded.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_data_mux
      mux2 u_mux2 (
        .a   (bus.a_data[gi]),
        .b   (bus.b_data[gi]),
        .s   (grant_b_s),
        .out (mux_out_s[gi])
      );
    end
  endgenerate

  // A grant continues the burst only when it goes to the current owner.
  assign keep_owner_s = (grant_a_s && (state_q == OWN_A)) ||
                        (grant_b_s && (state_q == OWN_B));

  // Next-state for the owner FSM, burst counter and output register.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_s) begin
      if (grant_a_s || grant_b_s) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_out_s;
        out_sel_d   = grant_b_s ? OWNER_B : OWNER_A;
        last_d      = grant_b_s ? OWNER_B : OWNER_A;
        state_d     = grant_b_s ? OWN_B : OWN_A;
        if (keep_owner_s) begin
          // Saturate so a long uncontended burst cannot wrap the counter.
          if (cnt_q >= MAX_CNT) begin
            cnt_d = MAX_CNT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end else begin
          cnt_d = CNT_W'(1'b1);
        end
      end else begin
        // Nothing to send: drain the stage, keep data/sel and last owner.
        out_valid_d = 1'b0;
        state_d     = IDLE;
        cnt_d       = {CNT_W{1'b0}};
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers; last resets to B so A wins first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= OWNER_B;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
      out_sel_q   <= OWNER_A;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (WIDTH = 8, MAX_BURST = 4).
// Inputs change just after the falling edge; readies are sampled 1 ns later,
// registered outputs at the next falling edge.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux_rr_arbiter_if #(.WIDTH(8)) bus_if ();

  mux_rr_arbiter #(
    .WIDTH     (8),
    .MAX_BURST (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check readies, then check the registered beat.
  task automatic cyc(input string tag,
                     input logic av, input logic [7:0] ad,
                     input logic bv, input logic [7:0] bd,
                     input logic ordy,
                     input logic e_ar, input logic e_br,
                     input logic e_ov, input logic [7:0] e_data, input logic e_sel);
    bus_if.a_valid   = av;
    bus_if.a_data    = ad;
    bus_if.b_valid   = bv;
    bus_if.b_data    = bd;
    bus_if.out_ready = ordy;
    #1;
    check_eq({tag, ".a_ready"}, {31'd0, bus_if.a_ready}, {31'd0, e_ar});
    check_eq({tag, ".b_ready"}, {31'd0, bus_if.b_ready}, {31'd0, e_br});
    @(negedge clk);
    check_eq({tag, ".out_valid"}, {31'd0, bus_if.out_valid}, {31'd0, e_ov});
    check_eq({tag, ".out_data"},  {24'd0, bus_if.out_data},  {24'd0, e_data});
    check_eq({tag, ".out_sel"},   {31'd0, bus_if.out_sel},   {31'd0, e_sel});
  endtask

  initial begin
    logic [8:0] sel_seq;
    logic [7:0] ad;
    logic [7:0] bd;
    logic       es;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.a_valid   = 1'b0;
    bus_if.a_data    = 8'h00;
    bus_if.b_valid   = 1'b0;
    bus_if.b_data    = 8'h00;
    bus_if.out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("rst.out_data",  {24'd0, bus_if.out_data},  32'd0);
    check_eq("rst.out_sel",   {31'd0, bus_if.out_sel},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesting from reset: A four beats, B four beats, then A again.
    sel_seq = 9'b011110000;
    for (int i = 0; i < 9; i++) begin
      ad = 8'hA0 + 8'(i);
      bd = 8'hB0 + 8'(i);
      es = sel_seq[i];
      cyc($sformatf("rr%0d", i), 1'b1, ad, 1'b1, bd, 1'b1,
          !es, es, 1'b1, es ? bd : ad, es);
    end

    // Downstream stall for three cycles: beat A8 must stay put, no readies.
    for (int k = 0; k < 3; k++) begin
      cyc($sformatf("stall%0d", k), 1'b1, 8'hC0 + 8'(k), 1'b1, 8'hD0 + 8'(k), 1'b0,
          1'b0, 1'b0, 1'b1, 8'hA8, 1'b0);
    end
    // Release: A still owns (cnt 1), one beat per cycle.
    cyc("rel0", 1'b1, 8'hC5, 1'b1, 8'hD5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC5, 1'b0);
    cyc("rel1", 1'b1, 8'hC6, 1'b1, 8'hD6, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC6, 1'b0);

    // Both drop: output drains, data/sel hold; last = A so B wins next contention.
    cyc("drop",  1'b0, 8'hE0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC6, 1'b0);
    cyc("idleb", 1'b1, 8'hE1, 1'b1, 8'hF1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hF1, 1'b1);

    // Only B requesting.
    cyc("bdrop", 1'b0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF1, 1'b1);
    cyc("b5a",   1'b0, 8'h11, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    cyc("b5b",   1'b0, 8'h12, 1'b1, 8'h5B, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5B, 1'b1);

    // A alone for nine beats: counter saturates, A keeps the grant.
    cyc("adrop", 1'b0, 8'h13, 1'b0, 8'h14, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5B, 1'b1);
    for (int i = 0; i < 9; i++) begin
      ad = 8'h20 + 8'(i);
      cyc($sformatf("asat%0d", i), 1'b1, ad, 1'b0, 8'h77, 1'b1,
          1'b1, 1'b0, 1'b1, ad, 1'b0);
    end
    // B arrives while A sits at the limit: B takes the next beat.
    cyc("bwin",  1'b1, 8'h30, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 1'b1);
    cyc("bcont", 1'b1, 8'h31, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1);

    // Asynchronous reset in the middle of a cycle while B holds a beat.
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("arst.out_data",  {24'd0, bus_if.out_data},  32'd0);
    check_eq("arst.out_sel",   {31'd0, bus_if.out_sel},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("post0", 1'b1, 8'h32, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 8'h32, 1'b0);
    cyc("post1", 1'b1, 8'h33, 1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
